// File: rtl/vpu_pkg.sv
// ============================================================================
// vpu_pkg : opcodes, FSM encoding and command record shared by the VPU blocks
// Rev 1.0
// ============================================================================
`default_nettype none

package vpu_pkg;

    localparam int unsigned VPU_DATA_W = 32;
    localparam int unsigned VPU_OP_W   = 10;
    localparam int unsigned VPU_ADDR_W = 10;
    localparam int unsigned VPU_LEN_W  = 10;

    localparam int unsigned VPU_OP_ADD    = 0;
    localparam int unsigned VPU_OP_SUB    = 1;
    localparam int unsigned VPU_OP_RELU   = 2;
    localparam int unsigned VPU_OP_MUL    = 3;
    localparam int unsigned VPU_OP_D_RELU = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_ISSUE = S_ISSUE,
        ST_DRAIN = S_DRAIN
    } vpu_state_e;

    typedef struct packed {
        logic [VPU_OP_W-1:0]   opcode;
        logic [VPU_ADDR_W-1:0] src0;
        logic [VPU_ADDR_W-1:0] src1;
        logic [VPU_ADDR_W-1:0] dst;
        logic [VPU_LEN_W-1:0]  len;
        logic                  scalar;
        logic [VPU_DATA_W-1:0] imm;
    } vpu_cmd_t;

    // Leading-zero count of a 27-bit mantissa frame; 27 when the input is zero.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vpu_op.sv
// ============================================================================
// vpu_op : combinational FP32 element datapath (ADD/SUB/RELU/MUL/D_RELU)
// Rev 1.0
// ============================================================================
`default_nettype none

module vpu_op
    import vpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 10
) (
    input  logic              start,
    input  logic [OP_W-1:0]   opcode,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] result
);

    localparam logic [31:0] C_QNAN = 32'h7fc0_0000;
    localparam logic [31:0] C_ONE  = 32'h3f80_0000;

    // Denormals are flushed to zero on input and output; round to nearest even.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic        sl, ss;
        logic [7:0]  ea, eb, el, es, d;
        logic [23:0] ml, ms, mr_m;
        logic [5:0]  sh;
        logic [49:0] wide;
        logic [26:0] al, asm;
        logic [27:0] s;
        logic [4:0]  lz;
        logic signed [9:0] e;
        logic        rnd;
        logic [24:0] mr;
        ea = a[30:23];
        eb = b[30:23];
        if (ea == 8'hFF) begin
            if (a[22:0] != 23'd0 || (eb == 8'hFF && (b[22:0] != 23'd0 || a[31] != b[31])))
                return C_QNAN;
            return a;
        end
        if (eb == 8'hFF) return b;
        if ({ea, a[22:0]} >= {eb, b[22:0]}) begin
            sl = a[31]; el = ea; ml = (ea == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
            ss = b[31]; es = eb; ms = (eb == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
        end else begin
            sl = b[31]; el = eb; ml = (eb == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
            ss = a[31]; es = ea; ms = (ea == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
        end
        d    = el - es;
        sh   = (d > 8'd49) ? 6'd49 : d[5:0];
        wide = {ms, 26'd0} >> sh;
        asm  = {wide[49:24], |wide[23:0]};
        al   = {ml, 3'b000};
        if (sl == ss) s = {1'b0, al} + {1'b0, asm};
        else          s = {1'b0, al} - {1'b0, asm};
        if (s == 28'd0) return 32'd0;
        e = $signed({2'b00, el});
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 10'sd1;
        end else begin
            lz = lzc27(s[26:0]);
            s  = s << lz;
            e  = e - $signed({5'd0, lz});
        end
        mr_m = s[26:3];
        rnd  = s[2] & (s[1] | s[0] | s[3]);
        mr   = {1'b0, mr_m} + {24'd0, rnd};
        if (mr[24]) begin
            mr = {1'b0, mr[24:1]};
            e  = e + 10'sd1;
        end
        if (e <= 10'sd0)   return {sl, 31'd0};
        if (e >= 10'sd255) return {sl, 8'hFF, 23'd0};
        return {sl, e[7:0], mr[22:0]};
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        sg, g, st, rnd;
        logic [7:0]  ea, eb;
        logic [23:0] ma, mb, m;
        logic [47:0] p;
        logic signed [9:0] e;
        logic [24:0] mr;
        sg = a[31] ^ b[31];
        ea = a[30:23];
        eb = b[30:23];
        if ((ea == 8'hFF && a[22:0] != 23'd0) || (eb == 8'hFF && b[22:0] != 23'd0))
            return C_QNAN;
        if (ea == 8'hFF || eb == 8'hFF)
            return (ea == 8'd0 || eb == 8'd0) ? C_QNAN : {sg, 8'hFF, 23'd0};
        if (ea == 8'd0 || eb == 8'd0) return {sg, 31'd0};
        ma = {1'b1, a[22:0]};
        mb = {1'b1, b[22:0]};
        p  = {24'd0, ma} * {24'd0, mb};
        e  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        if (p[47]) begin
            m = p[47:24]; g = p[23]; st = |p[22:0];
            e = e + 10'sd1;
        end else begin
            m = p[46:23]; g = p[22]; st = |p[21:0];
        end
        rnd = g & (st | m[0]);
        mr  = {1'b0, m} + {24'd0, rnd};
        if (mr[24]) begin
            mr = {1'b0, mr[24:1]};
            e  = e + 10'sd1;
        end
        if (e <= 10'sd0)   return {sg, 31'd0};
        if (e >= 10'sd255) return {sg, 8'hFF, 23'd0};
        return {sg, e[7:0], mr[22:0]};
    endfunction

    always_comb begin
        result = '0;
        if (start) begin
            case (opcode)
                OP_W'(VPU_OP_ADD):    result = fp_add(op_a, op_b);
                OP_W'(VPU_OP_SUB):    result = fp_add(op_a, {~op_b[31], op_b[30:0]});
                OP_W'(VPU_OP_MUL):    result = fp_mul(op_a, op_b);
                OP_W'(VPU_OP_RELU):   result = op_a[31] ? '0 : op_a;
                OP_W'(VPU_OP_D_RELU): result = (!op_a[31] && op_a[30:0] != 31'd0) ? C_ONE : '0;
                default:              result = '0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/vpu_ctrl.sv
// ============================================================================
// vpu_ctrl : vector command sequencer, scratchpad read -> vpu_op -> write back
// Optional feature macro: VPU_CTRL_SCALAR_EN (operand1 taken from cmd_imm)
// Rev 1.0
// ============================================================================
`default_nettype none

module vpu_ctrl
    import vpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 10,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_opcode,
    input  logic [ADDR_W-1:0] cmd_src0,
    input  logic [ADDR_W-1:0] cmd_src1,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_scalar,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr0,
    output logic [ADDR_W-1:0] rd_addr1,
    input  logic [DATA_W-1:0] rd_data0,
    input  logic [DATA_W-1:0] rd_data1,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    vpu_state_e        state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              drain_q, drain_d;
    logic [OP_W-1:0]   opcode_q, opcode_d;
    logic [ADDR_W-1:0] src0_q, src0_d;
    logic [ADDR_W-1:0] src1_q, src1_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;

    logic              v1_q, v1_d;
    logic [ADDR_W-1:0] waddr1_q, waddr1_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic              accept;
    logic              issue;
    logic [DATA_W-1:0] operand1;
    logic [DATA_W-1:0] op_res;

    assign cmd_ready = (state_q == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign issue     = (state_q == ST_ISSUE);
    assign busy      = (state_q != ST_IDLE);
    // Second DRAIN cycle coincides with the last write (or the only cycle for len 0).
    assign done      = (state_q == ST_DRAIN) && drain_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        drain_d  = drain_q;
        opcode_d = opcode_q;
        src0_d   = src0_q;
        src1_d   = src1_q;
        dst_d    = dst_q;
        len_d    = len_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    opcode_d = cmd_opcode;
                    src0_d   = cmd_src0;
                    src1_d   = cmd_src1;
                    dst_d    = cmd_dst;
                    len_d    = cmd_len;
                    cnt_d    = '0;
                    if (cmd_len == '0) begin
                        state_d = ST_DRAIN;
                        drain_d = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                        drain_d = 1'b0;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d = cnt_q + LEN_W'(1);
                if (cnt_q == len_q - LEN_W'(1)) begin
                    state_d = ST_DRAIN;
                    drain_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (drain_q) begin
                    state_d = ST_IDLE;
                    drain_d = 1'b0;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                drain_d = 1'b0;
            end
        endcase
    end

    assign rd_en    = issue;
    assign rd_addr0 = issue ? (src0_q + ADDR_W'(cnt_q)) : '0;
    assign rd_addr1 = issue ? (src1_q + ADDR_W'(cnt_q)) : '0;

`ifdef VPU_CTRL_SCALAR_EN
    logic              scalar_q, scalar_d;
    logic [DATA_W-1:0] imm_q, imm_d;

    always_comb begin
        scalar_d = scalar_q;
        imm_d    = imm_q;
        if (accept) begin
            scalar_d = cmd_scalar;
            imm_d    = cmd_imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scalar_q <= 1'b0;
            imm_q    <= '0;
        end else begin
            scalar_q <= scalar_d;
            imm_q    <= imm_d;
        end
    end

    // rd_addr1 keeps stepping in scalar mode; its returned data is simply unused.
    assign operand1 = scalar_q ? imm_q : rd_data1;
`else
    logic unused_scalar;
    assign unused_scalar = ^{cmd_scalar, cmd_imm};
    assign operand1      = rd_data1;
`endif

    vpu_op #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_vpu_op (
        .start  (v1_q),
        .opcode (opcode_q),
        .op_a   (rd_data0),
        .op_b   (operand1),
        .result (op_res)
    );

    always_comb begin
        v1_d      = issue;
        waddr1_d  = dst_q + ADDR_W'(cnt_q);
        wr_en_d   = v1_q;
        wr_addr_d = v1_q ? waddr1_q : '0;
        wr_data_d = op_res;
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            drain_q   <= 1'b0;
            opcode_q  <= '0;
            src0_q    <= '0;
            src1_q    <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            v1_q      <= 1'b0;
            waddr1_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            drain_q   <= drain_d;
            opcode_q  <= opcode_d;
            src0_q    <= src0_d;
            src1_q    <= src1_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            v1_q      <= v1_d;
            waddr1_q  <= waddr1_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vpu_ctrl.sv
// ============================================================================
// tb_vpu_ctrl : self-checking bench for vpu_ctrl (scratchpad model + write queue)
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vpu_ctrl;
    import vpu_pkg::*;

    localparam int DATA_W = 32;
    localparam int OP_W   = 10;
    localparam int ADDR_W = 10;
    localparam int LEN_W  = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_opcode = '0;
    logic [ADDR_W-1:0] cmd_src0 = '0, cmd_src1 = '0, cmd_dst = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic              cmd_scalar = 1'b0;
    logic [DATA_W-1:0] cmd_imm = '0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr0, rd_addr1;
    logic [DATA_W-1:0] rd_data0 = '0, rd_data1 = '0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy, done;

    always #5 clk = ~clk;

    vpu_ctrl #(
        .DATA_W (DATA_W), .OP_W (OP_W), .ADDR_W (ADDR_W), .LEN_W (LEN_W)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_opcode (cmd_opcode),
        .cmd_src0 (cmd_src0), .cmd_src1 (cmd_src1), .cmd_dst (cmd_dst),
        .cmd_len (cmd_len), .cmd_scalar (cmd_scalar), .cmd_imm (cmd_imm),
        .rd_en (rd_en), .rd_addr0 (rd_addr0), .rd_addr1 (rd_addr1),
        .rd_data0 (rd_data0), .rd_data1 (rd_data1),
        .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
        .busy (busy), .done (done)
    );

    // Scratchpad: two read ports, data one cycle after the strobe.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data0 <= mem[rd_addr0];
            rd_data1 <= mem[rd_addr1];
        end
    end

    typedef struct { logic [9:0] addr; logic [31:0] data; } wr_t;
    wr_t sb[$];
    wr_t mon_e;
    int  n_checks = 0;
    int  n_pass   = 0;
    int  n_done   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (done) n_done = n_done + 1;
        if (wr_en) begin
            if (sb.size() == 0) begin
                chk("unexpected_wr_en", 32'(wr_en), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
                chk("wr_data", wr_data, mon_e.data);
            end
        end
    end

    // Leaves the caller in cycle 1 of the accepted command.
    task automatic issue_cmd(input logic [9:0] op, input logic [9:0] s0, input logic [9:0] s1,
                             input logic [9:0] d, input logic [9:0] len,
                             input logic sc, input logic [31:0] imm);
        int guard;
        guard = 0;
        cmd_opcode = op; cmd_src0 = s0; cmd_src1 = s1; cmd_dst = d;
        cmd_len = len; cmd_scalar = sc; cmd_imm = imm;
        cmd_valid = 1'b1;
        while (!cmd_ready && guard < 100) begin
            step();
            guard++;
        end
        chk("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk({name, "_done"}, 32'(seen), 32'd1);
        step();
        chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    typedef struct { logic [9:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] exp; } vec_t;
    vec_t tbl [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int done_before;
        logic [31:0] g0, g1, e0, e1;

        tbl[0] = '{10'(VPU_OP_SUB),    32'h40400000, 32'h3f800000, 32'h40000000};
        tbl[1] = '{10'(VPU_OP_MUL),    32'h40000000, 32'h40400000, 32'h40c00000};
        tbl[2] = '{10'(VPU_OP_RELU),   32'hbf800000, 32'h00000000, 32'h00000000};
        tbl[3] = '{10'(VPU_OP_D_RELU), 32'h00000000, 32'h3f800000, 32'h00000000};
        tbl[4] = '{10'(VPU_OP_D_RELU), 32'h3f800000, 32'h3f800000, 32'h3f800000};
        tbl[5] = '{10'(VPU_OP_RELU),   32'h40400000, 32'h00000000, 32'h40400000};
        tbl[6] = '{10'(VPU_OP_ADD),    32'h3f800000, 32'hbf800000, 32'h00000000};
        tbl[7] = '{10'(VPU_OP_SUB),    32'h3f800000, 32'h40400000, 32'hc0000000};
        tbl[8] = '{10'(VPU_OP_MUL),    32'h3fc00000, 32'hc0000000, 32'hc0400000};
        tbl[9] = '{10'd5,              32'h3f800000, 32'h3f800000, 32'h00000000};

        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;

        // Reset values
        repeat (3) step();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_addr0", 32'(rd_addr0), 32'd0);
        chk("rst_rd_addr1", 32'(rd_addr1), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        rst_n = 1'b1;
        step();

        // ADD len 2 with cycle-exact timing
        mem[10'h000] = 32'h3f800000; mem[10'h001] = 32'h40000000;
        mem[10'h008] = 32'h40000000; mem[10'h009] = 32'h3f800000;
        sb.push_back('{10'h010, 32'h40400000});
        sb.push_back('{10'h011, 32'h40400000});
        issue_cmd(10'(VPU_OP_ADD), 10'h000, 10'h008, 10'h010, 10'd2, 1'b0, 32'd0);
        chk("add2_rd_addr0_c1", 32'(rd_addr0), 32'h000);
        chk("add2_rd_addr1_c1", 32'(rd_addr1), 32'h008);
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("add2_rd_en_c%0d", k), 32'(rd_en), 32'(k <= 2));
            chk($sformatf("add2_wr_en_c%0d", k), 32'(wr_en), 32'(k >= 3 && k <= 4));
            chk($sformatf("add2_done_c%0d", k), 32'(done), 32'(k == 4));
            chk($sformatf("add2_busy_c%0d", k), 32'(busy), 32'(k <= 4));
            chk($sformatf("add2_ready_c%0d", k), 32'(cmd_ready), 32'(k == 5));
            if (k < 5) step();
        end
        chk("add2_sb_empty", 32'(sb.size()), 32'd0);

        // Single-element opcode table
        for (int i = 0; i < 10; i++) begin
            mem[10'h040] = tbl[i].a;
            mem[10'h080] = tbl[i].b;
            sb.push_back('{10'(32'h0C0 + i), tbl[i].exp});
            issue_cmd(tbl[i].op, 10'h040, 10'h080, 10'(32'h0C0 + i), 10'd1, 1'b0, 32'd0);
            wait_done($sformatf("tbl%0d", i));
        end

        // len 0: done in cycle 1, ready in cycle 2, no traffic
        issue_cmd(10'(VPU_OP_ADD), 10'h000, 10'h000, 10'h300, 10'd0, 1'b0, 32'd0);
        chk("len0_done_c1", 32'(done), 32'd1);
        chk("len0_busy_c1", 32'(busy), 32'd1);
        chk("len0_ready_c1", 32'(cmd_ready), 32'd0);
        chk("len0_rd_en_c1", 32'(rd_en), 32'd0);
        step();
        chk("len0_ready_c2", 32'(cmd_ready), 32'd1);
        chk("len0_done_c2", 32'(done), 32'd0);
        chk("len0_rd_en_c2", 32'(rd_en), 32'd0);

        // Address wrap with cmd_valid held through the first command
        mem[10'h3FF] = 32'h3f800000; mem[10'h000] = 32'h40000000; mem[10'h001] = 32'h40400000;
        mem[10'h100] = 32'h3f800000; mem[10'h101] = 32'h3f800000; mem[10'h102] = 32'h3f800000;
        for (int r = 0; r < 2; r++) begin
            sb.push_back('{10'h3FE, 32'h40000000});
            sb.push_back('{10'h3FF, 32'h40400000});
            sb.push_back('{10'h000, 32'h40800000});
        end
        issue_cmd(10'(VPU_OP_ADD), 10'h3FF, 10'h100, 10'h3FE, 10'd3, 1'b0, 32'd0);
        cmd_valid = 1'b1;
        chk("wrap_rd_addr0_c1", 32'(rd_addr0), 32'h3FF);
        for (int k = 1; k <= 6; k++) begin
            chk($sformatf("wrap_ready_c%0d", k), 32'(cmd_ready), 32'(k == 6));
            step();
        end
        cmd_valid = 1'b0;
        chk("wrap_second_accept_busy", 32'(busy), 32'd1);
        wait_done("wrap");

        // Reset in cycle 2 of a len-8 command
        for (int i = 0; i < 8; i++) begin
            mem[10'(32'h200 + i)] = 32'h3f800000;
            mem[10'(32'h280 + i)] = 32'h3f800000;
        end
        issue_cmd(10'(VPU_OP_ADD), 10'h200, 10'h280, 10'h2C0, 10'd8, 1'b0, 32'd0);
        step();
        done_before = n_done;
        rst_n = 1'b0;
        #1;
        chk("midrst_rd_en", 32'(rd_en), 32'd0);
        chk("midrst_wr_en", 32'(wr_en), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_rd_addr0", 32'(rd_addr0), 32'd0);
        chk("midrst_wr_addr", 32'(wr_addr), 32'd0);
        chk("midrst_wr_data", wr_data, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (wr_en || done || rd_en) bad++;
        end
        chk("midrst_no_activity", 32'(bad), 32'd0);
        chk("midrst_no_done", 32'(n_done), 32'(done_before));
        mem[10'h040] = 32'h3f800000;
        mem[10'h080] = 32'h40000000;
        sb.push_back('{10'h0D0, 32'h40400000});
        issue_cmd(10'(VPU_OP_ADD), 10'h040, 10'h080, 10'h0D0, 10'd1, 1'b0, 32'd0);
        wait_done("post_reset");

        // Scalar operand: rd_data1 carries garbage when the feature is built
`ifdef VPU_CTRL_SCALAR_EN
        g0 = 32'hdeadbeef; g1 = 32'h7f7f1234;
        e0 = 32'h40000000; e1 = 32'h40c00000;
`else
        g0 = 32'h40400000; g1 = 32'h3f800000;
        e0 = 32'h40400000; e1 = 32'h40400000;
`endif
        mem[10'h060] = 32'h3f800000; mem[10'h061] = 32'h40400000;
        mem[10'h070] = g0;           mem[10'h071] = g1;
        sb.push_back('{10'h0E0, e0});
        sb.push_back('{10'h0E1, e1});
        issue_cmd(10'(VPU_OP_MUL), 10'h060, 10'h070, 10'h0E0, 10'd2, 1'b1, 32'h40000000);
        wait_done("scalar");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
